// File: rtl/lcd_write_sequencer.sv
// HD44780-style write sequencer: turns one LSU register write into RS/DATA setup, EN pulse,
// hold and execution wait, and reports busy/dropped/init_done. `LCD_INIT_EN adds a power-up init sequence.
module lcd_write_sequencer #(
    parameter int SETUP_CYC = 4,
    parameter int EN_CYC    = 25,
    parameter int HOLD_CYC  = 4,
    parameter int EXEC_CYC  = 2500,
    parameter int CLEAR_CYC = 82000,
    parameter int PWRUP_CYC = 2000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_status,
    output logic        o_lcd_on,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic [7:0]  o_lcd_data
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, EN_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                  max2(CLEAR_CYC, PWRUP_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT,
        S_INIT_PWR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lcd_on_q, lcd_on_d;
    logic               rs_q, rs_d;
    logic [7:0]         data_q, data_d;
    logic               dropped_q, dropped_d;
    logic               init_done;
    logic               is_clear;
    logic               cnt_last;
    logic               unused_wdata;

    assign unused_wdata = ^{i_wdata[29:9]};

`ifdef LCD_INIT_EN
    logic               init_done_q, init_done_d;
    logic [1:0]         init_idx_q, init_idx_d;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    assign init_done = init_done_q;
`else
    assign init_done = 1'b1;
`endif

    // Clear/home commands need the long execution wait.
    assign is_clear = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));
    assign cnt_last = (cnt_q == CNT_W'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lcd_on_d  = lcd_on_q;
        rs_d      = rs_q;
        data_d    = data_q;
        dropped_d = dropped_q;
`ifdef LCD_INIT_EN
        init_done_d = init_done_q;
        init_idx_d  = init_idx_q;
`endif

        if (i_wr) begin
            lcd_on_d = i_wdata[31];
            if (i_wdata[30]) begin
                dropped_d = 1'b0;
            end else if (state_q != S_IDLE) begin
                dropped_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_wr && !i_wdata[30]) begin
                    rs_d    = i_wdata[8];
                    data_d  = i_wdata[7:0];
                    state_d = S_SETUP;
                    cnt_d   = CNT_W'(SETUP_CYC);
                end
            end
            S_SETUP: begin
                if (cnt_last) begin
                    state_d = S_PULSE;
                    cnt_d   = CNT_W'(EN_CYC);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (cnt_last) begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_last) begin
                    state_d = S_WAIT;
                    cnt_d   = is_clear ? CNT_W'(CLEAR_CYC) : CNT_W'(EXEC_CYC);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (cnt_last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
`ifdef LCD_INIT_EN
                    if (!init_done_q) begin
                        if (init_idx_q == 2'd3) begin
                            init_done_d = 1'b1;
                        end else begin
                            init_idx_d = init_idx_q + 2'd1;
                            rs_d       = 1'b0;
                            data_d     = init_byte(init_idx_q + 2'd1);
                            state_d    = S_SETUP;
                            cnt_d      = CNT_W'(SETUP_CYC);
                        end
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef LCD_INIT_EN
            S_INIT_PWR: begin
                // Counter comes out of reset at zero, so the first cycle loads the delay.
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(PWRUP_CYC);
                end else if (cnt_last) begin
                    rs_d    = 1'b0;
                    data_d  = init_byte(2'd0);
                    state_d = S_SETUP;
                    cnt_d   = CNT_W'(SETUP_CYC);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
`ifdef LCD_INIT_EN
            state_q     <= S_INIT_PWR;
            init_done_q <= 1'b0;
            init_idx_q  <= 2'd0;
`else
            state_q     <= S_IDLE;
`endif
            cnt_q       <= '0;
            lcd_on_q    <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            dropped_q   <= 1'b0;
        end else begin
`ifdef LCD_INIT_EN
            init_done_q <= init_done_d;
            init_idx_q  <= init_idx_d;
`endif
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lcd_on_q    <= lcd_on_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            dropped_q   <= dropped_d;
        end
    end

    // EN decoded straight from state so an async reset drops it immediately.
    assign o_lcd_en   = (state_q == S_PULSE);
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_on   = lcd_on_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_data = data_q;
    assign o_status   = {29'b0, init_done, dropped_q, (state_q != S_IDLE)};

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer; CLEAR_CYC and PWRUP_CYC are shortened to bound run time.
module tb_lcd_write_sequencer;
    localparam int SETUP   = 4;
    localparam int ENC     = 25;
    localparam int HOLD    = 4;
    localparam int EXEC    = 2500;
    localparam int CLEAR   = 8200;
    localparam int PWRUP   = 100;
    localparam int T_EXEC  = SETUP + ENC + HOLD + EXEC;
    localparam int T_CLEAR = SETUP + ENC + HOLD + CLEAR;
    localparam int BUDGET  = 20000;
`ifdef LCD_INIT_EN
    localparam logic [31:0] ST_RST = 32'h1;
`else
    localparam logic [31:0] ST_RST = 32'h4;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_wr = 1'b0;
    logic [31:0] i_wdata = 32'h0;
    logic [31:0] o_status;
    logic        o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en;
    logic [7:0]  o_lcd_data;

    int n_tests = 0;
    int n_fail  = 0;
    int rise, hi, np, tot;

    lcd_write_sequencer #(
        .SETUP_CYC(SETUP), .EN_CYC(ENC), .HOLD_CYC(HOLD),
        .EXEC_CYC(EXEC), .CLEAR_CYC(CLEAR), .PWRUP_CYC(PWRUP)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_wr(i_wr), .i_wdata(i_wdata),
        .o_status(o_status), .o_lcd_on(o_lcd_on), .o_lcd_rs(o_lcd_rs),
        .o_lcd_rw(o_lcd_rw), .o_lcd_en(o_lcd_en), .o_lcd_data(o_lcd_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the write is sampled on the next rising edge.
    task automatic do_write(input logic [31:0] d);
        i_wr    = 1'b1;
        i_wdata = d;
        @(negedge i_clk);
        i_wr    = 1'b0;
    endtask

    // Starts at the negedge just after acceptance (cycle 0); optionally injects one write at cycle inj_c.
    task automatic run_xfer(input int inj_c, input logic [31:0] inj_d,
                            output int r, output int h, output int p, output int t);
        int   c;
        logic prev;
        c = 0; r = -1; h = 0; p = 0; prev = 1'b0;
        while (o_status[0] && c < BUDGET) begin
            if (o_lcd_en) begin
                h++;
                if (!prev) begin
                    p++;
                    if (r < 0) r = c;
                end
            end
            prev = o_lcd_en;
            if (c == inj_c) begin
                i_wr    = 1'b1;
                i_wdata = inj_d;
            end else begin
                i_wr = 1'b0;
            end
            @(negedge i_clk);
            c++;
        end
        i_wr = 1'b0;
        t = c;
        check("xfer_in_budget", 32'(c < BUDGET), 32'h1);
    endtask

`ifdef LCD_INIT_EN
    task automatic run_init();
        int         c;
        int         pulses;
        logic       prev;
        logic       busy_ok;
        logic [7:0] seen [4];
        c = 0; pulses = 0; prev = 1'b0; busy_ok = 1'b1;
        for (int k = 0; k < 4; k++) seen[k] = 8'h00;
        while (!o_status[2] && c < BUDGET) begin
            if (!o_status[0]) busy_ok = 1'b0;
            if (o_lcd_en && !prev) begin
                if (pulses < 4) seen[pulses] = o_lcd_data;
                check("init_rs", {31'b0, o_lcd_rs}, 32'h0);
                pulses++;
            end
            prev    = o_lcd_en;
            i_wr    = (c == 50);
            i_wdata = 32'h0000_0155;
            @(negedge i_clk);
            c++;
        end
        i_wr = 1'b0;
        check("init_in_budget", 32'(c < BUDGET), 32'h1);
        check("init_busy_held", {31'b0, busy_ok}, 32'h1);
        check("init_pulses", 32'(pulses), 32'd4);
        check("init_b0", {24'b0, seen[0]}, 32'h38);
        check("init_b1", {24'b0, seen[1]}, 32'h0C);
        check("init_b2", {24'b0, seen[2]}, 32'h01);
        check("init_b3", {24'b0, seen[3]}, 32'h06);
        check("init_status", o_status, 32'h6);
        do_write(32'h4000_0000);
        check("init_clr_drop", o_status, 32'h4);
    endtask
`endif

    initial begin
        #12;
        check("rst_status", o_status, ST_RST);
        check("rst_pins", {o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data}, 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;
`ifdef LCD_INIT_EN
        run_init();
`endif

        // Data write with LCD_ON, then a second write mid-transfer that must be dropped
        do_write(32'h8000_0141);
        check("t1_status", o_status, 32'h5);
        check("t1_pins", {o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_data}, {1'b1, 1'b1, 1'b0, 8'h41});
        run_xfer(10, 32'h0000_0142, rise, hi, np, tot);
        check("t1_en_rise", 32'(rise), 32'd4);
        check("t1_en_high", 32'(hi), 32'd25);
        check("t3_pulses", 32'(np), 32'd1);
        check("t1_busy_len", 32'(tot), 32'(T_EXEC));
        check("t3_data_kept", {23'b0, o_lcd_rs, o_lcd_data}, 32'h141);
        check("t3_status", o_status, 32'h6);
        check("t3_lcd_on", {31'b0, o_lcd_on}, 32'h0);
        do_write(32'h4000_0000);
        check("t3_clear", o_status, 32'h4);
        repeat (6) @(negedge i_clk);
        check("t3_no_pulse", {31'b0, o_lcd_en}, 32'h0);

        // Clear/home command waits versus normal waits
        do_write(32'h0000_0001);
        check("t2_pins", {23'b0, o_lcd_rs, o_lcd_data}, 32'h001);
        run_xfer(-1, 32'h0, rise, hi, np, tot);
        check("t2_en_high", 32'(hi), 32'd25);
        check("t2_clear_len", 32'(tot), 32'(T_CLEAR));
        do_write(32'h0000_0102);
        run_xfer(-1, 32'h0, rise, hi, np, tot);
        check("t2_rs1_len", 32'(tot), 32'(T_EXEC));
        do_write(32'h0000_0002);
        run_xfer(-1, 32'h0, rise, hi, np, tot);
        check("t2_home_len", 32'(tot), 32'(T_CLEAR));
        do_write(32'h0000_0003);
        run_xfer(-1, 32'h0, rise, hi, np, tot);
        check("t2_cmd03_len", 32'(tot), 32'(T_EXEC));

        // Write on the final WAIT cycle is dropped; one cycle later it is accepted
        do_write(32'h0000_0110);
        run_xfer(T_EXEC - 1, 32'h0000_0120, rise, hi, np, tot);
        check("t5_edge_len", 32'(tot), 32'(T_EXEC));
        check("t5_dropped", o_status, 32'h6);
        check("t5_data_kept", {24'b0, o_lcd_data}, 32'h10);
        do_write(32'h0000_0120);
        check("t5_accept", o_status, 32'h7);
        check("t5_data_new", {24'b0, o_lcd_data}, 32'h20);
        run_xfer(-1, 32'h0, rise, hi, np, tot);
        check("t5_len", 32'(tot), 32'(T_EXEC));
        do_write(32'h4000_0000);

        // Async reset in the middle of the EN pulse
        do_write(32'h8000_0133);
        begin
            int c;
            c = 0;
            while (!o_lcd_en && c < 100) begin
                @(negedge i_clk);
                c++;
            end
            check("t4_en_seen", {31'b0, o_lcd_en}, 32'h1);
        end
        repeat (9) @(negedge i_clk);
        #1 i_reset = 1'b1;
        #1;
        check("t4_en_drop", {31'b0, o_lcd_en}, 32'h0);
        check("t4_pins", {o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data}, 32'h0);
        check("t4_status", o_status, ST_RST);
        @(negedge i_clk);
        i_reset = 1'b0;
`ifdef LCD_INIT_EN
        run_init();
`endif
        do_write(32'h0000_0144);
        check("t4_accept", o_status, 32'h5);
        check("t4_pins_new", {23'b0, o_lcd_rs, o_lcd_data}, 32'h144);
        run_xfer(-1, 32'h0, rise, hi, np, tot);
        check("t4_en_rise", 32'(rise), 32'd4);
        check("t4_len", 32'(tot), 32'(T_EXEC));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
